// File: rtl/serial_word_receiver_pkg.sv
// Shared types and sizing helpers for the serial word receiver slice.
package serial_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  // One extra bit so the counter can hold DATA_WIDTH itself.
  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } rx_state_e;

endpackage

// File: rtl/serial_word_receiver_if.sv
// Serial bit input, word output handshake and status bundle of the receiver.
// master = receiver side, slave = upstream/consumer side.
interface serial_word_receiver_if #(
  parameter int DATA_WIDTH = serial_pkg::DATA_WIDTH_DEF
);

  logic                  Enable_In;
  logic                  Serial_Data_In;
  logic                  Bit_Valid_In;
  logic                  Frame_Start_In;
  logic [DATA_WIDTH-1:0] Parallel_Data_Out;
  logic                  Data_Valid_Out;
  logic                  Data_Ready_In;
  logic                  Overrun_Out;
  logic                  Overrun_Clear_In;
  logic                  Frame_Error_Out;
  logic                  Busy_Out;

  modport master (
    input  Enable_In,
    input  Serial_Data_In,
    input  Bit_Valid_In,
    input  Frame_Start_In,
    input  Data_Ready_In,
    input  Overrun_Clear_In,
    output Parallel_Data_Out,
    output Data_Valid_Out,
    output Overrun_Out,
    output Frame_Error_Out,
    output Busy_Out
  );

  modport slave (
    output Enable_In,
    output Serial_Data_In,
    output Bit_Valid_In,
    output Frame_Start_In,
    output Data_Ready_In,
    output Overrun_Clear_In,
    input  Parallel_Data_Out,
    input  Data_Valid_Out,
    input  Overrun_Out,
    input  Frame_Error_Out,
    input  Busy_Out
  );

endinterface

// File: rtl/serial_word_receiver_word_output_register.sv
// One-word valid/ready holding register with sticky overrun; a load lands on the same edge.
// A load is accepted when empty or being drained this cycle, otherwise dropped and flagged.
module word_output_register #(
  parameter int DATA_WIDTH = serial_pkg::DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_vld_i,
  input  logic [DATA_WIDTH-1:0] load_dat_i,
  input  logic                  rdy_i,
  input  logic                  overrun_clr_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  vld_o,
  output logic                  overrun_o
);

  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  vld_q, vld_d;
  logic                  overrun_q, overrun_d;
  logic                  accept;
  logic                  can_load;

  assign accept   = vld_q && rdy_i;
  assign can_load = !vld_q || accept;

  always_comb begin
    dat_d     = dat_q;
    vld_d     = vld_q;
    overrun_d = overrun_q;
    if (accept) begin
      vld_d = 1'b0;
    end
    if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end
    // Set is evaluated after clear so a coincident overrun wins.
    if (load_vld_i) begin
      if (can_load) begin
        dat_d = load_dat_i;
        vld_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_q     <= '0;
      vld_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dat_q     <= dat_d;
      vld_q     <= vld_d;
      overrun_q <= overrun_d;
    end
  end

  assign dat_o     = dat_q;
  assign vld_o     = vld_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_word_receiver.sv
// MSB-first serial-to-parallel word receiver with frame alignment; word valid right after its last bit edge.
// Output holds one word under valid/ready; a completed word with nowhere to go sets sticky overrun.
module serial_word_receiver
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH = serial_pkg::DATA_WIDTH_DEF
) (
  input  logic                   Clk_In,
  input  logic                   Reset_In,
  serial_word_receiver_if.master bus
);

  localparam int CW = count_width(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  ferr_q, ferr_d;

  logic                  bit_acc;
  logic                  start;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  word_done;

  logic [DATA_WIDTH-1:0] out_dat;
  logic                  out_vld;
  logic                  out_overrun;

  assign bit_acc = bus.Enable_In && bus.Bit_Valid_In;
  assign start   = bit_acc && bus.Frame_Start_In;
  assign shifted = {shift_q[DATA_WIDTH-2:0], bus.Serial_Data_In};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shift_d   = shift_q;
    ferr_d    = 1'b0;
    word_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = shifted;
          count_d = CW'(1);
          state_d = RECEIVE;
        end
      end
      RECEIVE: begin
        if (start) begin
          // The FSM leaves RECEIVE on completion, so any start here is early.
          shift_d = shifted;
          count_d = CW'(1);
          ferr_d  = 1'b1;
        end else if (bit_acc) begin
          shift_d = shifted;
          count_d = count_q + CW'(1);
          if (count_q == CW'(DATA_WIDTH - 1)) begin
            word_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      count_q <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
    end
  end

  word_output_register #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk_i        (Clk_In),
    .rst_i        (Reset_In),
    .load_vld_i   (word_done),
    .load_dat_i   (shifted),
    .rdy_i        (bus.Data_Ready_In),
    .overrun_clr_i(bus.Overrun_Clear_In),
    .dat_o        (out_dat),
    .vld_o        (out_vld),
    .overrun_o    (out_overrun)
  );

  assign bus.Parallel_Data_Out = out_dat;
  assign bus.Data_Valid_Out    = out_vld;
  assign bus.Overrun_Out       = out_overrun;
  assign bus.Frame_Error_Out   = ferr_q;
  assign bus.Busy_Out          = (state_q == RECEIVE);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: bits driven and outputs sampled on the falling edge.
module tb_serial_word_receiver;

  logic Clk_In   = 1'b0;
  logic Reset_In = 1'b1;
  int   tests    = 0;
  int   fails    = 0;
  int   ferr_cnt = 0;
  int   e0;

  serial_word_receiver_if #(.DATA_WIDTH(32)) bus ();

  serial_word_receiver #(.DATA_WIDTH(32)) dut (
    .Clk_In  (Clk_In),
    .Reset_In(Reset_In),
    .bus     (bus)
  );

  always #5 Clk_In = ~Clk_In;

  always @(negedge Clk_In) begin
    if (bus.Frame_Error_Out === 1'b1) ferr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge Clk_In);
  endtask

  // Sends w[n-1:0] MSB first, Frame_Start on the first bit. Optional 5-cycle
  // enable-low gap before bit index gap_at; optional ready raised for the last bit.
  task automatic send_bits(input logic [31:0] w, input int n, input bit fs,
                           input int gap_at, input bit rdy_last);
    for (int i = n - 1; i >= 0; i--) begin
      if (i == gap_at) begin
        for (int g = 0; g < 5; g++) begin
          bus.Enable_In      = 1'b0;
          bus.Bit_Valid_In   = g[0];
          bus.Frame_Start_In = 1'b1;
          bus.Serial_Data_In = ~w[i];
          @(negedge Clk_In);
        end
        chk("busy_in_gap", {31'b0, bus.Busy_Out}, 32'd1);
      end
      bus.Enable_In      = 1'b1;
      bus.Bit_Valid_In   = 1'b1;
      bus.Serial_Data_In = w[i];
      bus.Frame_Start_In = fs && (i == n - 1);
      if (rdy_last && i == 0) bus.Data_Ready_In = 1'b1;
      @(negedge Clk_In);
    end
    bus.Bit_Valid_In   = 1'b0;
    bus.Frame_Start_In = 1'b0;
  endtask

  initial begin
    bus.Enable_In        = 1'b1;
    bus.Serial_Data_In   = 1'b0;
    bus.Bit_Valid_In     = 1'b0;
    bus.Frame_Start_In   = 1'b0;
    bus.Data_Ready_In    = 1'b1;
    bus.Overrun_Clear_In = 1'b0;

    // Reset state
    cycles(2);
    chk("rst_dat", bus.Parallel_Data_Out, 32'h0);
    chk("rst_vld", {31'b0, bus.Data_Valid_Out}, 32'd0);
    chk("rst_ovr", {31'b0, bus.Overrun_Out}, 32'd0);
    chk("rst_busy", {31'b0, bus.Busy_Out}, 32'd0);
    Reset_In = 1'b0;
    cycles(1);

    // Single word, consumer ready
    e0 = ferr_cnt;
    send_bits(32'hA5A5_1234, 32, 1'b1, -1, 1'b0);
    chk("w1_vld", {31'b0, bus.Data_Valid_Out}, 32'd1);
    chk("w1_dat", bus.Parallel_Data_Out, 32'hA5A5_1234);
    chk("w1_busy", {31'b0, bus.Busy_Out}, 32'd0);
    cycles(1);
    chk("w1_vld_one_cycle", {31'b0, bus.Data_Valid_Out}, 32'd0);
    chk("w1_ovr", {31'b0, bus.Overrun_Out}, 32'd0);
    chk("w1_no_ferr", 32'(ferr_cnt - e0), 32'd0);

    // Back-to-back words, consumer stalled -> overrun
    bus.Data_Ready_In = 1'b0;
    send_bits(32'hDEAD_BEEF, 32, 1'b1, -1, 1'b0);
    chk("w2_vld", {31'b0, bus.Data_Valid_Out}, 32'd1);
    chk("w2_dat", bus.Parallel_Data_Out, 32'hDEAD_BEEF);
    chk("w2_ovr_before", {31'b0, bus.Overrun_Out}, 32'd0);
    send_bits(32'h0000_0001, 32, 1'b1, -1, 1'b0);
    chk("w3_ovr", {31'b0, bus.Overrun_Out}, 32'd1);
    chk("w3_held_dat", bus.Parallel_Data_Out, 32'hDEAD_BEEF);
    cycles(40);
    chk("w3_held_vld", {31'b0, bus.Data_Valid_Out}, 32'd1);
    chk("w3_held_dat_late", bus.Parallel_Data_Out, 32'hDEAD_BEEF);
    bus.Data_Ready_In = 1'b1;
    cycles(1);
    chk("w3_accept_vld", {31'b0, bus.Data_Valid_Out}, 32'd0);
    chk("w3_accept_ovr", {31'b0, bus.Overrun_Out}, 32'd1);
    cycles(3);
    chk("w3_ovr_sticky", {31'b0, bus.Overrun_Out}, 32'd1);
    bus.Overrun_Clear_In = 1'b1;
    cycles(1);
    bus.Overrun_Clear_In = 1'b0;
    chk("ovr_cleared", {31'b0, bus.Overrun_Out}, 32'd0);

    // Early restart -> one frame error, later word intact
    bus.Data_Ready_In = 1'b0;
    e0 = ferr_cnt;
    send_bits(32'h0000_03FF, 10, 1'b1, -1, 1'b0);
    chk("partial_busy", {31'b0, bus.Busy_Out}, 32'd1);
    send_bits(32'h1234_5678, 32, 1'b1, -1, 1'b0);
    chk("ferr_once", 32'(ferr_cnt - e0), 32'd1);
    chk("fe_dat", bus.Parallel_Data_Out, 32'h1234_5678);
    chk("fe_vld", {31'b0, bus.Data_Valid_Out}, 32'd1);
    chk("fe_ovr", {31'b0, bus.Overrun_Out}, 32'd0);
    bus.Data_Ready_In = 1'b1;
    cycles(1);
    bus.Data_Ready_In = 1'b0;

    // Idle bits without start are discarded
    send_bits(32'h0000_00B7, 8, 1'b0, -1, 1'b0);
    chk("idle_vld", {31'b0, bus.Data_Valid_Out}, 32'd0);
    chk("idle_busy", {31'b0, bus.Busy_Out}, 32'd0);

    // Enable low mid-word with toggling bit-valid and start
    e0 = ferr_cnt;
    send_bits(32'hCAFE_F00D, 32, 1'b1, 15, 1'b0);
    chk("gap_dat", bus.Parallel_Data_Out, 32'hCAFE_F00D);
    chk("gap_vld", {31'b0, bus.Data_Valid_Out}, 32'd1);
    chk("gap_no_ferr", 32'(ferr_cnt - e0), 32'd0);

    // Reset mid-word with a pending word and overrun set
    send_bits(32'h1111_1111, 32, 1'b1, -1, 1'b0);
    chk("pre_rst_ovr", {31'b0, bus.Overrun_Out}, 32'd1);
    send_bits(32'hFFFF_FFFF, 20, 1'b1, -1, 1'b0);
    #2 Reset_In = 1'b1;
    #1;
    chk("mid_rst_dat", bus.Parallel_Data_Out, 32'h0);
    chk("mid_rst_vld", {31'b0, bus.Data_Valid_Out}, 32'd0);
    chk("mid_rst_ovr", {31'b0, bus.Overrun_Out}, 32'd0);
    chk("mid_rst_busy", {31'b0, bus.Busy_Out}, 32'd0);
    chk("mid_rst_ferr", {31'b0, bus.Frame_Error_Out}, 32'd0);
    @(negedge Clk_In);
    Reset_In = 1'b0;
    e0 = ferr_cnt;
    send_bits(32'hFFFF_FFFF, 32, 1'b1, -1, 1'b0);
    chk("post_rst_dat", bus.Parallel_Data_Out, 32'hFFFF_FFFF);
    chk("post_rst_vld", {31'b0, bus.Data_Valid_Out}, 32'd1);
    chk("post_rst_no_ferr", 32'(ferr_cnt - e0), 32'd0);
    bus.Data_Ready_In = 1'b1;
    cycles(1);
    bus.Data_Ready_In = 1'b0;

    // Completion on the same edge the previous word is accepted
    send_bits(32'hAAAA_5555, 32, 1'b1, -1, 1'b0);
    chk("co_first_dat", bus.Parallel_Data_Out, 32'hAAAA_5555);
    send_bits(32'h0F0F_0F0F, 32, 1'b1, -1, 1'b1);
    chk("co_vld", {31'b0, bus.Data_Valid_Out}, 32'd1);
    chk("co_dat", bus.Parallel_Data_Out, 32'h0F0F_0F0F);
    chk("co_ovr", {31'b0, bus.Overrun_Out}, 32'd0);
    cycles(1);
    chk("co_drained", {31'b0, bus.Data_Valid_Out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Serial-in, parallel-out word receiver that sits directly downstream of the 32-bit PISO shift register and rebuilds its MSB-first bit stream into 32-bit words. It has a bit-count state machine, frame alignment, and a one-word output holding register. The register hands words to the consumer over a valid/ready handshake and reports overrun and framing errors.

## Interface
- DATA_WIDTH, 32, word width; bit counter is $clog2(DATA_WIDTH)+1 bits wide (6 at default)
- Clk_In  input  1  clock; all sampling and state updates on rising edge
- Reset_In  input  1  reset, asynchronous, active-high
- Enable_In  input  1  bit-sampling enable; when low, Bit_Valid_In/Frame_Start_In ignored, FSM and shift register hold
- Serial_Data_In  input  1  serial bit, MSB first
- Bit_Valid_In  input  1  Serial_Data_In carries a valid bit this cycle
- Frame_Start_In  input  1  qualifies the current valid bit as bit DATA_WIDTH-1 (first bit) of a word
- Parallel_Data_Out  output  DATA_WIDTH  received word, stable while Data_Valid_Out high
- Data_Valid_Out  output  1  output register holds an unconsumed word
- Data_Ready_In  input  1  consumer accepts word when Data_Valid_Out && Data_Ready_In
- Overrun_Out  output  1  sticky: a completed word was dropped
- Overrun_Clear_In  input  1  synchronous clear of Overrun_Out
- Frame_Error_Out  output  1  one-cycle pulse: partial word discarded by early Frame_Start_In
- Busy_Out  output  1  FSM in RECEIVE

## Operation
- Bit accepted = Enable_In && Bit_Valid_In. Start = bit accepted && Frame_Start_In.
- FSM states:
  - IDLE: accepted bits without Frame_Start_In are discarded. On start: shift_reg <= {shift_reg[DATA_WIDTH-2:0], Serial_Data_In}, count <= 1, go to RECEIVE.
  - RECEIVE, accepted bit without start: shift in the bit and count++.
  - RECEIVE, start before count reaches DATA_WIDTH: discard the partial word, restart with count <= 1, pulse Frame_Error_Out. Stay in RECEIVE.
- Word complete: the accepted bit that brings count to DATA_WIDTH. On the same edge the assembled word, including this bit, is transferred to the output register and the FSM returns to IDLE.
  - Transfer succeeds if the output register is empty, or if it is being consumed this cycle (Data_Valid_Out && Data_Ready_In). Data_Valid_Out is then 1.
  - Otherwise the new word is dropped, the output register keeps the old word, and Overrun_Out is set.
- Handshake: Data_Valid_Out clears on the accepting edge unless a new word is loaded on that same edge. Parallel_Data_Out must not change while Data_Valid_Out=1 && Data_Ready_In=0.
- Overrun_Out: set on overrun, cleared by Overrun_Clear_In. If set and clear occur together, set wins.
- Enable_In low mid-word: the partial word and count are retained, and reception resumes when Enable_In returns. The output handshake keeps operating while Enable_In is low.

## Timing
- Reset values: Parallel_Data_Out=0, Data_Valid_Out=0, Overrun_Out=0, Frame_Error_Out=0, Busy_Out=0. Internally FSM=IDLE, count=0, shift_reg=0.
- Reset asserted mid-word or while a word is pending: everything is discarded immediately, with no completion and no error pulse.
- Latency: the last bit is sampled at edge N, and Data_Valid_Out and Parallel_Data_Out are valid after edge N.
- Minimum word period is DATA_WIDTH cycles. A start on the cycle after completion is legal (back-to-back frames).
- The upstream PISO updates on the falling edge, so bits are stable at the rising sampling edge.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package serial_pkg: DATA_WIDTH default, count width function, FSM state enum {IDLE, RECEIVE}.
- One sub-module, word_output_register: the valid/ready holding register plus overrun detection. The FSM and shift register stay in the top level.

## Test plan
- Reset, then Frame_Start_In with 32 consecutive bits of 32'hA5A5_1234 MSB first, Data_Ready_In=1 -> Data_Valid_Out for one cycle with Parallel_Data_Out=32'hA5A5_1234, and no error flags.
- Two back-to-back words 32'hDEAD_BEEF and 32'h0000_0001, with Data_Ready_In=0 until 40 cycles after the second word ends -> first word held, Overrun_Out=1, second word dropped. After the accept, Data_Valid_Out=0 and Overrun_Out stays 1 until Overrun_Clear_In.
- Start, 10 bits, then a new start and 32 bits of 32'h1234_5678 -> Frame_Error_Out pulses once and output = 32'h1234_5678.
- Bits with no Frame_Start_In while IDLE -> no output, Busy_Out=0. Enable_In low for 5 cycles mid-word with Bit_Valid_In toggling -> word unchanged after completion.
- Reset_In pulsed at bit 20 -> all outputs 0 immediately. A following full word of 32'hFFFF_FFFF is received correctly.
- Completion coincident with consumer acceptance of the previous word -> new word loaded, Data_Valid_Out stays 1, Overrun_Out=0.
